// File: rtl/jtcontra_gfx_lyrscan.sv
// Per-line tilemap fetcher: walks each enabled layer, reads scan RAM
// tile code/attr and ROM pixel words, writes pixels to a double line buffer.
//
// Ports:
//   rst, clk          synchronous active-high reset, single clock
//   LHBL, LVBL        blanking (active low); LHBL rise in active video starts a line
//   vrender, flip     line being prepared, screen flip
//   lyr_en            per-layer enable
//   hpos, vpos        per-layer scroll, layer l at [9l+:9] / [8l+:8]
//   scan_addr         {lyr, vn[7:3], hn[7:3]}
//   code_scan,
//   attr_scan         scan RAM data, two cycles after scan_addr
//   rom_cs, rom_addr,
//   rom_ok, rom_data  pixel ROM request/response
//   line_we, line_lyr,
//   line_addr,
//   line_din          line buffer write port, {line, x} / {prio, pal, pix}
//   line              buffer half being written
//   done              all layers finished for this line
module jtcontra_gfx_lyrscan #(
    parameter int LAYERS = 2,
    parameter int DW     = 16,
    parameter int HW     = 320,
    localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int PPW   = DW / 4
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic                  LHBL,
    input  logic                  LVBL,
    input  logic [8:0]            vrender,
    input  logic                  flip,
    input  logic [LAYERS-1:0]     lyr_en,
    input  logic [9*LAYERS-1:0]   hpos,
    input  logic [8*LAYERS-1:0]   vpos,
    output logic [LW+9:0]         scan_addr,
    input  logic [7:0]            code_scan,
    input  logic [7:0]            attr_scan,
    output logic                  rom_cs,
    output logic [16:0]           rom_addr,
    input  logic                  rom_ok,
    input  logic [DW-1:0]         rom_data,
    output logic                  line_we,
    output logic [LW-1:0]         line_lyr,
    output logic [9:0]            line_addr,
    output logic [7:0]            line_din,
    output logic                  line,
    output logic                  done
);

    typedef enum logic [3:0] {
        IDLE, HSET, VSET, SCAN0, SCAN1,
        ROMREQ, ROMWAIT, DUMP, NEXT
    } st_t;

    st_t             st;
    logic [LW-1:0]   lyr;
    logic [8:0]      hn;
    logic [8:0]      vn;
    logic [9:0]      hr;
    logic [12:0]     code;
    logic [2:0]      pal;
    logic            prio;
    logic [DW-1:0]   data;
    logic [2:0]      cnt;
    logic            lhbl_l;

    logic            start;
    logic [LW-1:0]   first_lyr;
    logic [LW-1:0]   nxt_lyr;
    logic            nxt_ok;
    logic [8:0]      hpos_l;
    logic [7:0]      vpos_l;
    logic [8:0]      vn_nxt;
    logic [8:0]      hn_nxt;
    logic            hr_ok;
    logic            hr_end;
    logic [8:0]      x_w;
    logic            unused_vn;

    assign start  = LHBL & ~lhbl_l & LVBL;
    assign hpos_l = hpos[int'(lyr)*9 +: 9];
    assign vpos_l = vpos[int'(lyr)*8 +: 8];
    assign vn_nxt = (vrender ^ {9{flip}}) + {1'b0, vpos_l};
    assign hn_nxt = hn + 9'(PPW);

    // hr is signed: negative while skipping pixels left of the screen
    assign hr_ok  = ~hr[9] && (hr <  10'(HW));
    assign hr_end = ~hr[9] && (hr >= 10'(HW));
    assign x_w    = flip ? (9'(HW-1) - hr[8:0]) : hr[8:0];

    // only vn[7:0] addresses the map; bit 8 just follows the 9-bit wrap
    assign unused_vn = vn[8];

    always_comb begin
        first_lyr = '0;
        nxt_lyr   = '0;
        nxt_ok    = 1'b0;
        for (int i = LAYERS-1; i >= 0; i--) begin
            if (lyr_en[i]) first_lyr = LW'(i);
            if (lyr_en[i] && i > int'(lyr)) begin
                nxt_lyr = LW'(i);
                nxt_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            lyr       <= '0;
            hn        <= '0;
            vn        <= '0;
            hr        <= '0;
            code      <= '0;
            pal       <= '0;
            prio      <= 1'b0;
            data      <= '0;
            cnt       <= '0;
            lhbl_l    <= 1'b1;
            scan_addr <= '0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            line_we   <= 1'b0;
            line_lyr  <= '0;
            line_addr <= '0;
            line_din  <= '0;
            line      <= 1'b0;
            done      <= 1'b1;
        end else begin
            lhbl_l  <= LHBL;
            line_we <= 1'b0;
            if (start) begin
                // a start always wins, even mid-line: any fetched word is dropped
                line   <= ~line;
                rom_cs <= 1'b0;
                if (|lyr_en) begin
                    done <= 1'b0;
                    lyr  <= first_lyr;
                    st   <= HSET;
                end else begin
                    done <= 1'b1;
                    st   <= IDLE;
                end
            end else begin
                unique case (st)
                    IDLE: ;
                    HSET: begin
                        hn <= hpos_l;
                        hr <= 10'd0 - {7'd0, hpos_l[2:0] & 3'(PPW-1)};
                        st <= VSET;
                    end
                    VSET: begin
                        vn        <= vn_nxt;
                        scan_addr <= {lyr, vn_nxt[7:3], hn[7:3]};
                        st        <= SCAN0;
                    end
                    SCAN0: st <= SCAN1;
                    SCAN1: begin
                        code <= {attr_scan[7:3], code_scan};
                        pal  <= attr_scan[2:0];
                        prio <= attr_scan[6];
                        st   <= ROMREQ;
                    end
                    ROMREQ: begin
                        rom_cs   <= 1'b1;
                        rom_addr <= {code, vn[2:0],
                                     (DW == 16) ? hn[2] : 1'b0};
                        st       <= ROMWAIT;
                    end
                    ROMWAIT: begin
                        if (rom_ok) begin
                            data   <= rom_data;
                            rom_cs <= 1'b0;
                            cnt    <= '0;
                            st     <= DUMP;
                        end
                    end
                    DUMP: begin
                        line_we   <= hr_ok;
                        line_lyr  <= lyr;
                        line_addr <= {line, x_w};
                        line_din  <= {prio, pal, data[DW-1 -: 4]};
                        data      <= data << 4;
                        hr        <= hr + 10'd1;
                        cnt       <= cnt + 3'd1;
                        if (cnt == 3'(PPW-1)) st <= NEXT;
                    end
                    NEXT: begin
                        hn <= hn_nxt;
                        if (hr_end) begin
                            if (nxt_ok) begin
                                lyr <= nxt_lyr;
                                st  <= HSET;
                            end else begin
                                done <= 1'b1;
                                st   <= IDLE;
                            end
                        end else if (DW == 16 && hn_nxt[2]) begin
                            // second half of the same tile: code still valid
                            st <= ROMREQ;
                        end else begin
                            st <= VSET;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule
